result_reader: RTL

//  Drains the product RAM after a multiply run: reads DEPTH words of DATA_W bits
//  and streams each word as two OUT_W-bit beats over a valid/ready interface.
//  It is the read side of the datapath's output RAM, which the datapath fills

---
 rtl/result_reader_pkg.sv | 27 ++
 rtl/result_reader_if.sv | 31 +++
 rtl/result_reader_addr_counter.sv | 37 +++
 rtl/result_reader.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/result_reader_pkg.sv
// ============================================================================
// Module  : result_reader_pkg
// Brief   : Shared sizing constants and drain FSM state encoding.
// Revision: 1.0
// ============================================================================
`default_nettype none

package result_reader_pkg;

    localparam int ADDR_W = 3;
    localparam int DEPTH  = 8;
    localparam int DATA_W = 32;
    localparam int OUT_W  = 16;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_RD   = 3'd1,
        S_LAT  = 3'd2,
        S_HI   = 3'd3,
        S_LO   = 3'd4,
        S_CHK  = 3'd5,
        S_FIN  = 3'd6
    } state_e;

endpackage

`default_nettype wire

// File: rtl/result_reader_if.sv
// ============================================================================
// Module  : result_reader_if
// Brief   : Product RAM read port plus valid/ready output beat stream.
// Revision: 1.0
// ============================================================================
`default_nettype none

interface result_reader_if;
    import result_reader_pkg::*;

    logic              ram_rd_en;
    logic [ADDR_W-1:0] ram_rd_addr;
    logic [DATA_W-1:0] ram_rd_data;
    logic [OUT_W-1:0]  out_data;
    logic              out_valid;
    logic              out_ready;
    logic              out_last;

    modport master (
        output ram_rd_en, ram_rd_addr, out_data, out_valid, out_last,
        input  ram_rd_data, out_ready
    );

    modport slave (
        input  ram_rd_en, ram_rd_addr, out_data, out_valid, out_last,
        output ram_rd_data, out_ready
    );

endinterface

`default_nettype wire

// File: rtl/result_reader_addr_counter.sv
// ============================================================================
// Module  : rr_addr_counter
// Brief   : Read-address up counter with clear and DEPTH-1 terminal flag.
// Revision: 1.0
// ============================================================================
`default_nettype none

module rr_addr_counter #(
    parameter int ADDR_W = 3,
    parameter int DEPTH  = 8
) (
    input  wire logic              clk,
    input  wire logic              rst,
    input  wire logic              inc,
    input  wire logic              clear,
    output logic      [ADDR_W-1:0] count,
    output logic                   terminal
);

    localparam logic [ADDR_W-1:0] c_last = ADDR_W'(DEPTH - 1);

    logic [ADDR_W-1:0] r_count;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            r_count <= '0;
        end else if (inc) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign count    = r_count;
    assign terminal = (r_count == c_last);

endmodule

`default_nettype wire

// File: rtl/result_reader.sv
// ============================================================================
// Module  : result_reader
// Brief   : Drains the product RAM, streaming each word as hi/lo beats.
//           Optional trailing checksum beat with RESULT_CHECKSUM_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module result_reader #(
    parameter int DEPTH = result_reader_pkg::DEPTH
) (
    input  wire logic         clk,
    input  wire logic         rst,
    input  wire logic         start,
    output logic              busy,
    output logic              done,
    result_reader_if.master   bus
);
    import result_reader_pkg::*;

    state_e            r_state;
    logic [DATA_W-1:0] r_buf;
    logic              r_rd_en;
    logic              r_valid;
    logic              r_last;
    logic              r_busy;
    logic              r_done;
`ifdef RESULT_CHECKSUM_EN
    logic [OUT_W-1:0]  r_sum;
`endif

    logic [OUT_W-1:0]  w_out_data;
    logic [ADDR_W-1:0] w_addr;
    logic              w_terminal;
    logic              w_accept;
    logic              w_inc;
    logic              w_clear;

    assign w_accept = r_valid & bus.out_ready;
    // The final word does not advance the counter; FIN clears it instead.
    assign w_inc    = (r_state == S_LO) & w_accept & ~w_terminal;
    assign w_clear  = (r_state == S_FIN);

    rr_addr_counter #(
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) u_addr_counter (
        .clk      (clk),
        .rst      (rst),
        .inc      (w_inc),
        .clear    (w_clear),
        .count    (w_addr),
        .terminal (w_terminal)
    );

    always_comb begin
        w_out_data = '0;
        case (r_state)
            S_HI:    w_out_data = r_buf[DATA_W-1:OUT_W];
            S_LO:    w_out_data = r_buf[OUT_W-1:0];
`ifdef RESULT_CHECKSUM_EN
            S_CHK:   w_out_data = r_sum;
`endif
            default: w_out_data = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_buf   <= '0;
            r_rd_en <= 1'b0;
            r_valid <= 1'b0;
            r_last  <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
`ifdef RESULT_CHECKSUM_EN
            r_sum   <= '0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state <= S_RD;
                        r_rd_en <= 1'b1;
                        r_busy  <= 1'b1;
`ifdef RESULT_CHECKSUM_EN
                        r_sum   <= '0;
`endif
                    end
                end
                S_RD: begin
                    r_rd_en <= 1'b0;
                    r_state <= S_LAT;
                end
                S_LAT: begin
                    r_buf   <= bus.ram_rd_data;
                    r_valid <= 1'b1;
                    r_state <= S_HI;
                end
                S_HI: begin
                    if (w_accept) begin
                        r_state <= S_LO;
`ifdef RESULT_CHECKSUM_EN
                        r_sum   <= r_sum + w_out_data;
`else
                        r_last  <= w_terminal;
`endif
                    end
                end
                S_LO: begin
                    if (w_accept) begin
`ifdef RESULT_CHECKSUM_EN
                        r_sum <= r_sum + w_out_data;
`endif
                        if (!w_terminal) begin
                            r_state <= S_RD;
                            r_rd_en <= 1'b1;
                            r_valid <= 1'b0;
                        end else begin
`ifdef RESULT_CHECKSUM_EN
                            // Valid stays high: the checksum beat follows directly.
                            r_state <= S_CHK;
                            r_last  <= 1'b1;
`else
                            r_state <= S_FIN;
                            r_valid <= 1'b0;
                            r_last  <= 1'b0;
                            r_done  <= 1'b1;
`endif
                        end
                    end
                end
`ifdef RESULT_CHECKSUM_EN
                S_CHK: begin
                    if (w_accept) begin
                        r_state <= S_FIN;
                        r_valid <= 1'b0;
                        r_last  <= 1'b0;
                        r_done  <= 1'b1;
                    end
                end
`endif
                S_FIN: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.ram_rd_en   = r_rd_en;
    assign bus.ram_rd_addr = w_addr;
    assign bus.out_data    = w_out_data;
    assign bus.out_valid   = r_valid;
    assign bus.out_last    = r_last;
    assign busy            = r_busy;
    assign done            = r_done;

endmodule

`default_nettype wire
